// File: rtl/mem_arbiter_if.sv
// Bus bundle between the core's fetch/load-store ports, the arbiter and the
// memory macro. The arbiter takes the slave view; the core/memory side
// (or a testbench standing in for both) takes the master view.
interface mem_arbiter_if #(
  parameter int XLEN = 32
);
  // Instruction-fetch port
  logic            if_req;
  logic [XLEN-1:0] if_addr;
  logic            if_gnt;
  logic            if_rvalid;
  logic [XLEN-1:0] if_rdata;

  // Load/store port
  logic            d_req;
  logic            d_we;
  logic [3:0]      d_be;
  logic [XLEN-1:0] d_addr;
  logic [XLEN-1:0] d_wdata;
  logic            d_gnt;
  logic            d_rvalid;
  logic [XLEN-1:0] d_rdata;

  // Memory macro port
  logic            mem_req;
  logic            mem_we;
  logic [3:0]      mem_be;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  d_req, d_we, d_be, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output d_req, d_we, d_be, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one unified memory between instruction fetch and
// load/store. One grant per cycle, combinational in the request cycle;
// a latency-matched tag pipeline steers each response back to its issuer,
// and a data-streak counter bounds how long loads/stores can starve fetch.
module mem_arbiter #(
  parameter int XLEN        = 32,
  parameter int MEM_LAT     = 1,   // 1..7
  parameter int MAX_DSTREAK = 4    // 1..15
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
);

  localparam logic [3:0] max_ds = 4'(MAX_DSTREAK);

  typedef enum logic {
    OWNER_FETCH = 1'b0,
    OWNER_DATA  = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } tag_t;

  logic            if_gnt;
  logic            d_gnt;
  logic            mem_req;
  logic [3:0]      dstreak_q;
  logic [3:0]      dstreak_d;
  tag_t            tag_q [MEM_LAT];
  tag_t            tag_d;
  tag_t            tag_tail;

  logic            mem_we_d;
  logic [3:0]      mem_be_d;
  logic [XLEN-1:0] mem_addr_d;
  logic [XLEN-1:0] mem_wdata_d;

  // Pick at most one winner this cycle; data wins ties until its streak cap.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (!reset) begin
      if (bus.d_req && (!bus.if_req || (dstreak_q < max_ds))) begin
        d_gnt = 1'b1;
      end else if (bus.if_req) begin
        if_gnt = 1'b1;
      end
    end
  end

  assign mem_req = if_gnt | d_gnt;

  // Count consecutive data grants taken while fetch was waiting.
  always_comb begin
    dstreak_d = 4'd0;
    if (d_gnt && bus.if_req) begin
      dstreak_d = (dstreak_q == max_ds) ? max_ds : dstreak_q + 4'd1;
    end
  end

  // Streak counter register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs regardless of statement order.
    if (reset) begin
      dstreak_q <= 4'd0;
    end else begin
      dstreak_q <= dstreak_d;
    end
  end

  // Steer the winning requester's payload onto the memory port.
  always_comb begin
    mem_we_d    = 1'b0;
    mem_be_d    = 4'b0000;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    if (if_gnt) begin
      mem_be_d   = 4'b1111;
      mem_addr_d = bus.if_addr;
    end else if (d_gnt) begin
      mem_we_d    = bus.d_we;
      mem_be_d    = bus.d_be;
      mem_addr_d  = bus.d_addr;
      mem_wdata_d = bus.d_wdata;
    end
  end

  assign tag_d = '{valid: mem_req, owner: d_gnt ? OWNER_DATA : OWNER_FETCH};

  // Tag pipeline: stage 0 records this cycle's grant, later stages shift so
  // the tail lines up with the memory read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: this small tag array is reset because its valid bits directly
      // create rvalid; the bulk data path needs no reset since it is only
      // qualified by these valids.
      for (int i = 0; i < MEM_LAT; i++) begin
        tag_q[i] <= '{valid: 1'b0, owner: OWNER_FETCH};
      end
    end else begin
      tag_q[0] <= tag_d;
      for (int i = 1; i < MEM_LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign tag_tail = tag_q[MEM_LAT-1];

  assign bus.if_gnt    = if_gnt;
  assign bus.d_gnt     = d_gnt;
  assign bus.mem_req   = mem_req;
  assign bus.mem_we    = mem_we_d;
  assign bus.mem_be    = mem_be_d;
  assign bus.mem_addr  = mem_addr_d;
  assign bus.mem_wdata = mem_wdata_d;

  assign bus.if_rvalid = tag_tail.valid && (tag_tail.owner == OWNER_FETCH);
  assign bus.d_rvalid  = tag_tail.valid && (tag_tail.owner == OWNER_DATA);
  assign bus.if_rdata  = bus.mem_rdata;
  assign bus.d_rdata   = bus.mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. Two instances: u_a with MEM_LAT=2 and
// u_b with MEM_LAT=3, both MAX_DSTREAK=4. Each has a memory stand-in that
// returns (addr + 0x100) exactly MEM_LAT cycles after a request.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic reset_a = 1'b1;
  logic reset_b = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.XLEN(32)) bus_a ();
  mem_arbiter_if #(.XLEN(32)) bus_b ();

  mem_arbiter #(.XLEN(32), .MEM_LAT(2), .MAX_DSTREAK(4)) u_a (
    .clk   (clk),
    .reset (reset_a),
    .bus   (bus_a.slave)
  );

  mem_arbiter #(.XLEN(32), .MEM_LAT(3), .MAX_DSTREAK(4)) u_b (
    .clk   (clk),
    .reset (reset_b),
    .bus   (bus_b.slave)
  );

  // Memory stand-ins: fixed latency, ignore reset.
  logic [31:0] mpipe_a [2];
  logic [31:0] mpipe_b [3];

  always @(posedge clk) begin
    mpipe_a[0] <= bus_a.mem_req ? bus_a.mem_addr + 32'h100 : 32'h0BAD_0000;
    mpipe_a[1] <= mpipe_a[0];
    mpipe_b[0] <= bus_b.mem_req ? bus_b.mem_addr + 32'h100 : 32'h0BAD_0000;
    mpipe_b[1] <= mpipe_b[0];
    mpipe_b[2] <= mpipe_b[1];
  end

  assign bus_a.mem_rdata = mpipe_a[1];
  assign bus_b.mem_rdata = mpipe_b[2];

  task automatic idle_inputs();
    bus_a.if_req = 1'b0; bus_a.if_addr = '0;
    bus_a.d_req = 1'b0;  bus_a.d_we = 1'b0; bus_a.d_be = 4'b0;
    bus_a.d_addr = '0;   bus_a.d_wdata = '0;
    bus_b.if_req = 1'b0; bus_b.if_addr = '0;
    bus_b.d_req = 1'b0;  bus_b.d_we = 1'b0; bus_b.d_be = 4'b0;
    bus_b.d_addr = '0;   bus_b.d_wdata = '0;
  endtask

  // Reset held 3 cycles with both requests high: all grants/rvalids stay 0.
  task automatic test_reset();
    logic [4:0] obs;
    idle_inputs();
    bus_a.if_req = 1'b1; bus_a.d_req = 1'b1;
    bus_b.if_req = 1'b1; bus_b.d_req = 1'b1;
    reset_a = 1'b1; reset_b = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      obs = {bus_a.mem_req, bus_a.if_gnt, bus_a.d_gnt, bus_a.if_rvalid, bus_a.d_rvalid};
      checks++;
      if (obs !== 5'b0) begin
        errors++;
        $display("FAIL reset_a cyc%0d: {mem_req,if_gnt,d_gnt,if_rv,d_rv} got %b expected 00000", c, obs);
      end
      obs = {bus_b.mem_req, bus_b.if_gnt, bus_b.d_gnt, bus_b.if_rvalid, bus_b.d_rvalid};
      checks++;
      if (obs !== 5'b0) begin
        errors++;
        $display("FAIL reset_b cyc%0d: {mem_req,if_gnt,d_gnt,if_rv,d_rv} got %b expected 00000", c, obs);
      end
    end
    @(negedge clk);
    reset_a = 1'b0; reset_b = 1'b0;
    idle_inputs();
  endtask

  // u_a (MEM_LAT=2): fetches 0x0,0x4,0x8 back to back.
  task automatic test_fetch_only();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus_a.if_req  = (i < 3);
      bus_a.if_addr = 32'(4 * i);
      #1;
      if (i < 3) begin
        checks++;
        if ({bus_a.if_gnt, bus_a.d_gnt, bus_a.mem_req} !== 3'b101) begin
          errors++;
          $display("FAIL fetch_gnt cyc%0d: {if_gnt,d_gnt,mem_req} got %b expected 101", i,
                   {bus_a.if_gnt, bus_a.d_gnt, bus_a.mem_req});
        end
        checks++;
        if ({bus_a.mem_we, bus_a.mem_be, bus_a.mem_addr, bus_a.mem_wdata} !==
            {1'b0, 4'b1111, 32'(4 * i), 32'h0}) begin
          errors++;
          $display("FAIL fetch_mux cyc%0d: we=%b be=%b addr=%h wdata=%h expected 0/1111/%h/0", i,
                   bus_a.mem_we, bus_a.mem_be, bus_a.mem_addr, bus_a.mem_wdata, 32'(4 * i));
        end
      end
      checks++;
      if ({bus_a.if_rvalid, bus_a.d_rvalid} !== {(i >= 2 && i <= 4), 1'b0}) begin
        errors++;
        $display("FAIL fetch_rvalid cyc%0d: {if_rv,d_rv} got %b expected %b", i,
                 {bus_a.if_rvalid, bus_a.d_rvalid}, {(i >= 2 && i <= 4), 1'b0});
      end
      if (i >= 2 && i <= 4) begin
        checks++;
        if (bus_a.if_rdata !== 32'h100 + 32'(4 * (i - 2))) begin
          errors++;
          $display("FAIL fetch_rdata cyc%0d: got %h expected %h", i, bus_a.if_rdata,
                   32'h100 + 32'(4 * (i - 2)));
        end
      end
    end
    idle_inputs();
  endtask

  // u_a: data write passes straight through and is acked at t+2.
  task automatic test_write();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus_a.d_req   = (i == 0);
      bus_a.d_we    = (i == 0);
      bus_a.d_be    = 4'b0011;
      bus_a.d_addr  = 32'h40;
      bus_a.d_wdata = 32'hDEAD_BEEF;
      #1;
      if (i == 0) begin
        checks++;
        if ({bus_a.d_gnt, bus_a.if_gnt, bus_a.mem_req, bus_a.mem_we, bus_a.mem_be,
             bus_a.mem_addr, bus_a.mem_wdata} !==
            {1'b1, 1'b0, 1'b1, 1'b1, 4'b0011, 32'h40, 32'hDEAD_BEEF}) begin
          errors++;
          $display("FAIL write_pass: gnt=%b req=%b we=%b be=%b addr=%h wdata=%h expected 1/1/1/0011/40/deadbeef",
                   bus_a.d_gnt, bus_a.mem_req, bus_a.mem_we, bus_a.mem_be,
                   bus_a.mem_addr, bus_a.mem_wdata);
        end
      end else if (i == 1) begin
        checks++;
        if ({bus_a.mem_req, bus_a.mem_we, bus_a.mem_be, bus_a.mem_addr, bus_a.mem_wdata} !== '0) begin
          errors++;
          $display("FAIL idle_mux: req=%b we=%b be=%b addr=%h wdata=%h expected all zero",
                   bus_a.mem_req, bus_a.mem_we, bus_a.mem_be, bus_a.mem_addr, bus_a.mem_wdata);
        end
      end
      checks++;
      if ({bus_a.d_rvalid, bus_a.if_rvalid} !== {(i == 2), 1'b0}) begin
        errors++;
        $display("FAIL write_ack cyc%0d: {d_rv,if_rv} got %b expected %b", i,
                 {bus_a.d_rvalid, bus_a.if_rvalid}, {(i == 2), 1'b0});
      end
    end
    idle_inputs();
  endtask

  // u_b: both requesting for 12 cycles gives D,D,D,D,I repeating.
  task automatic test_starvation();
    logic exp_d;
    @(negedge clk);
    bus_b.if_req = 1'b1; bus_b.if_addr = 32'h10;
    bus_b.d_req  = 1'b1; bus_b.d_addr  = 32'h20;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      exp_d = ((i % 5) != 4);
      checks++;
      if ({bus_b.d_gnt, bus_b.if_gnt} !== {exp_d, ~exp_d}) begin
        errors++;
        $display("FAIL starve cyc%0d: {d_gnt,if_gnt} got %b expected %b", i,
                 {bus_b.d_gnt, bus_b.if_gnt}, {exp_d, ~exp_d});
      end
    end
    @(negedge clk);
    idle_inputs();
    repeat (4) @(negedge clk);
  endtask

  // u_b (MEM_LAT=3): I,D,I,D issued back to back, responses routed in order.
  task automatic test_interleaved();
    logic [31:0] addr   [4] = '{32'h10, 32'h20, 32'h14, 32'h24};
    logic        exp_if [8] = '{0, 0, 0, 1, 0, 1, 0, 0};
    logic        exp_d  [8] = '{0, 0, 0, 0, 1, 0, 1, 0};
    logic [31:0] exp_dt [8] = '{0, 0, 0, 32'h110, 32'h120, 32'h114, 32'h124, 0};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus_b.if_req  = (i < 4) && (i % 2 == 0);
      bus_b.d_req   = (i < 4) && (i % 2 == 1);
      bus_b.if_addr = (i < 4) ? addr[i] : 32'h0;
      bus_b.d_addr  = (i < 4) ? addr[i] : 32'h0;
      #1;
      checks++;
      if ({bus_b.if_rvalid, bus_b.d_rvalid} !== {exp_if[i], exp_d[i]}) begin
        errors++;
        $display("FAIL inter_rvalid cyc%0d: {if_rv,d_rv} got %b expected %b", i,
                 {bus_b.if_rvalid, bus_b.d_rvalid}, {exp_if[i], exp_d[i]});
      end
      if (exp_if[i]) begin
        checks++;
        if (bus_b.if_rdata !== exp_dt[i]) begin
          errors++;
          $display("FAIL inter_if_rdata cyc%0d: got %h expected %h", i, bus_b.if_rdata, exp_dt[i]);
        end
      end
      if (exp_d[i]) begin
        checks++;
        if (bus_b.d_rdata !== exp_dt[i]) begin
          errors++;
          $display("FAIL inter_d_rdata cyc%0d: got %h expected %h", i, bus_b.d_rdata, exp_dt[i]);
        end
      end
    end
    idle_inputs();
  endtask

  // u_b: data read granted at t, one-cycle reset at t+1 drops the response.
  task automatic test_reset_midflight();
    @(negedge clk);
    bus_b.d_req = 1'b1; bus_b.d_addr = 32'h30;
    #1;
    checks++;
    if (bus_b.d_gnt !== 1'b1) begin
      errors++;
      $display("FAIL midflight_gnt: d_gnt got %b expected 1", bus_b.d_gnt);
    end
    @(negedge clk);
    reset_b = 1'b1; bus_b.d_addr = 32'h34;
    #1;
    checks++;
    if ({bus_b.d_gnt, bus_b.mem_req} !== 2'b00) begin
      errors++;
      $display("FAIL midflight_rst_gnt: {d_gnt,mem_req} got %b expected 00", {bus_b.d_gnt, bus_b.mem_req});
    end
    for (int i = 2; i < 5; i++) begin
      @(negedge clk);
      reset_b = 1'b0;
      bus_b.d_req = 1'b0;
      #1;
      checks++;
      if ({bus_b.d_rvalid, bus_b.if_rvalid} !== 2'b00) begin
        errors++;
        $display("FAIL midflight_drop t+%0d: {d_rv,if_rv} got %b expected 00", i,
                 {bus_b.d_rvalid, bus_b.if_rvalid});
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_fetch_only();
    test_write();
    test_starvation();
    test_interleaved();
    test_reset_midflight();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter that shares one unified instruction/data memory between the core's instruction-fetch port and its load/store port. It issues at most one memory request per cycle and tracks in-flight requests in a latency-matched tag pipeline so each read response returns to the requester that issued it. A streak counter bounds how long data accesses can starve fetch. It sits between the core's `imem_*`/`dmem_*` side and the memory macro.

## Interface
- `XLEN`, 32: address/data width.
- `MEM_LAT`, 1: fixed memory read latency in cycles. Legal range 1..7.
- `MAX_DSTREAK`, 4: maximum consecutive data grants while fetch waits. Legal range 1..15.

- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `if_req`  in  1  fetch request; held with `if_addr` until `if_gnt`.
- `if_addr`  in  XLEN  fetch address.
- `if_gnt`  out  1  fetch request accepted this cycle.
- `if_rvalid`  out  1  fetch response valid.
- `if_rdata`  out  XLEN  fetch response data.
- `d_req`  in  1  data request; held with its payload until `d_gnt`.
- `d_we`  in  1  data write enable.
- `d_be`  in  4  data byte enables.
- `d_addr`  in  XLEN  data address.
- `d_wdata`  in  XLEN  data write data.
- `d_gnt`  out  1  data request accepted this cycle.
- `d_rvalid`  out  1  data response valid; read data, or write completion ack.
- `d_rdata`  out  XLEN  data response data; don't-care for writes.
- `mem_req`  out  1  memory request this cycle.
- `mem_we`  out  1  memory write enable.
- `mem_be`  out  4  memory byte enables.
- `mem_addr`  out  XLEN  memory address.
- `mem_wdata`  out  XLEN  memory write data.
- `mem_rdata`  in  XLEN  memory data, valid exactly `MEM_LAT` cycles after the accepting cycle.

## Operation
- **Grant is combinational, same cycle.** At most one of `if_gnt`/`d_gnt` is high. `mem_req = if_gnt | d_gnt`.
- **Winner selection:**
  - Only one request present: that requester wins.
  - Both requesting and `dstreak < MAX_DSTREAK`: data wins.
  - Both requesting and `dstreak == MAX_DSTREAK`: fetch wins.
- **`dstreak` counter (4-bit, registered):**
  - Data grant while `if_req` is high: increment, saturating at `MAX_DSTREAK`.
  - Fetch grant, or `if_req` low: clear to 0.
- **Memory mux:**
  - Fetch grant: `mem_addr = if_addr`, `mem_we = 0`, `mem_be = 4'b1111`, `mem_wdata = 0`.
  - Data grant: data payload passed through unchanged.
  - No grant: `mem_we = 0`, `mem_be = 0`, `mem_addr = 0`, `mem_wdata = 0`.
- **Tag pipeline:** `MEM_LAT` stages, each holding `{valid, owner}` with owner 0 = fetch, 1 = data.
  - Stage 0 loads `{mem_req, d_gnt}` every edge; later stages shift.
  - Tail stage drives `if_rvalid = valid & ~owner` and `d_rvalid = valid & owner`.
  - `if_rdata = d_rdata = mem_rdata`, unconditionally.
- **Writes** occupy a pipeline slot and produce `d_rvalid` with `MEM_LAT` latency, same as reads.
- **No backpressure:** memory accepts every request, so throughput is one grant per cycle.
- **Requester contract:** once `req` is asserted, requesters hold `req` and payload until `gnt`. Deassertion before grant is tolerated; nothing is issued for the withdrawn request.

## Timing
- **During reset:**
  - `if_gnt`, `d_gnt`, `mem_req` forced to 0 combinationally.
  - At each edge with `reset` high, all tag valids and `dstreak` clear.
  - `if_rvalid`/`d_rvalid` are 0 from the first edge with `reset` high until `MEM_LAT` cycles after the first post-reset grant.
- **Reset mid-operation:** in-flight responses are dropped. Memory data arriving after reset produces no `rvalid`.
- **Latency:** a request granted in cycle t gets its response in cycle t+`MEM_LAT`.
- **Ordering:** responses per requester return in issue order. Responses from both ports never coincide, since one grant per cycle.
- **Back-to-back grants** to alternating owners in consecutive cycles must route each response correctly.
- **Simultaneous events:**
  - Grant in cycle t and tail response in cycle t are independent.
  - Counter update and saturation happen on the same edge as the grant.

## Test plan
- **Reset:** hold `reset` 3 cycles with `if_req = d_req = 1` → `mem_req`, both gnts, both rvalids are 0 throughout.
- **Fetch only:** `MEM_LAT = 2`, `if_req` with `if_addr = 0x0, 0x4, 0x8` in consecutive cycles; memory returns `addr + 0x100` → `if_gnt` every cycle, `if_rdata = 0x100, 0x104, 0x108` in cycles t+2..t+4, `d_rvalid` stays 0.
- **Starvation bound:** `MAX_DSTREAK = 4`, `if_req` and `d_req` both held high 12 cycles → grant pattern D,D,D,D,I repeating (`d_gnt` cycles 0–3, `if_gnt` cycle 4, `d_gnt` 5–8, `if_gnt` 9, ...).
- **Write passthrough:** `d_we = 1`, `d_be = 4'b0011`, `d_addr = 0x40`, `d_wdata = 0xDEADBEEF` → same-cycle `mem_we = 1`, `mem_be = 4'b0011`, `mem_addr = 0x40`, `mem_wdata = 0xDEADBEEF`; `d_rvalid` at t+`MEM_LAT`.
- **Interleaved routing:** `MEM_LAT = 3`, alternating fetch/data reads at 0x10/0x20/0x14/0x24 → rvalids alternate I,D,I,D starting at t+3 with matching data.
- **Reset mid-flight:** `MEM_LAT = 3`, grant a data read, assert `reset` 1 cycle at t+1 → no `d_rvalid` at t+3.
